// File: rtl/full_mas_serializer_pkg.sv
// Shared types and line-level constants for the 23-lane master serializer / deserializer pair.
// Optional parity frame bit is enabled by defining FULL_MAS_SERIALIZER_PARITY_EN.
package full_mas_ser_pkg;

  localparam int unsigned DEF_LANES     = 23;
  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_IDLE_BITS = 1;

  localparam logic START_BIT  = 1'b1;
  localparam logic IDLE_LEVEL = 1'b0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    GAP    = 3'd4
  } state_t;

  // Per-lane output mux select, driven once by the shared FSM.
  typedef enum logic [1:0] {
    SEL_IDLE   = 2'd0,
    SEL_START  = 2'd1,
    SEL_DATA   = 2'd2,
    SEL_PARITY = 2'd3
  } line_sel_t;

endpackage

// File: rtl/full_mas_serializer_if.sv
// Word handshake and serial line bundle for full_mas_serializer.
// Unaffected by FULL_MAS_SERIALIZER_PARITY_EN.
interface full_mas_serializer_if
  import full_mas_ser_pkg::*;
#(
  parameter int unsigned LANES = DEF_LANES,
  parameter int unsigned WIDTH = DEF_WIDTH
);
  logic                   valid_i;
  logic                   ready_o;
  logic [LANES*WIDTH-1:0] data_i;
  logic [LANES-1:0]       serial_o;
  logic                   busy_o;
  logic                   done_o;

  modport master (
    output valid_i, data_i,
    input  ready_o, serial_o, busy_o, done_o
  );

  modport slave (
    input  valid_i, data_i,
    output ready_o, serial_o, busy_o, done_o
  );
endinterface

// File: rtl/full_mas_serializer_lane.sv
// serializer_8b: one lane's shift register and registered line driver.
// FULL_MAS_SERIALIZER_PARITY_EN adds a captured even-parity bit.
module serializer_8b
  import full_mas_ser_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  line_sel_t        sel,
  input  logic [WIDTH-1:0] data,
  output logic             serial
);

  logic [WIDTH-1:0] shreg;
`ifdef FULL_MAS_SERIALIZER_PARITY_EN
  logic par;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    par <= 1'b0;
    else if (load) par <= ^data;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg  <= '0;
      serial <= IDLE_LEVEL;
    end else begin
      if (load)       shreg <= data;
      else if (shift) shreg <= {1'b0, shreg[WIDTH-1:1]};
      case (sel)
        SEL_START:  serial <= START_BIT;
        SEL_DATA:   serial <= shreg[0];
`ifdef FULL_MAS_SERIALIZER_PARITY_EN
        SEL_PARITY: serial <= par;
`endif
        default:    serial <= IDLE_LEVEL;
      endcase
    end
  end

endmodule

// File: rtl/full_mas_serializer.sv
// Lockstep 23-lane serializer: one word per handshake, framed as start, data LSB first, low gap.
// Define FULL_MAS_SERIALIZER_PARITY_EN to insert an even-parity bit per lane after the data bits.
module full_mas_serializer
  import full_mas_ser_pkg::*;
#(
  parameter int unsigned LANES     = DEF_LANES,
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned IDLE_BITS = DEF_IDLE_BITS
) (
  input logic                  clk,
  input logic                  reset,
  full_mas_serializer_if.slave bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned GAP_W = $clog2(IDLE_BITS + 1);

  state_t     state;
  logic [CNT_W-1:0] bit_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic       xfer;
  logic       shift_en;
  line_sel_t  sel;

  assign bus.ready_o = (state == IDLE);
  assign bus.busy_o  = (state != IDLE);
  assign xfer        = bus.valid_i && (state == IDLE);
  assign shift_en    = (state == DATA);

  // Lines are registered in the lanes, so the select reflects the state one cycle ahead of the pin.
  always_comb begin
    sel = SEL_IDLE;
    case (state)
      START:   sel = SEL_START;
      DATA:    sel = SEL_DATA;
`ifdef FULL_MAS_SERIALIZER_PARITY_EN
      PARITY:  sel = SEL_PARITY;
`endif
      default: sel = SEL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      bus.done_o <= 1'b0;
    end else begin
      bus.done_o <= 1'b0;
      case (state)
        IDLE: if (xfer) state <= START;
        START: begin
          state   <= DATA;
          bit_cnt <= '0;
        end
        DATA: begin
          if (bit_cnt == CNT_W'(WIDTH - 1)) begin
`ifdef FULL_MAS_SERIALIZER_PARITY_EN
            state   <= PARITY;
`else
            state   <= GAP;
            gap_cnt <= '0;
`endif
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
`ifdef FULL_MAS_SERIALIZER_PARITY_EN
        PARITY: begin
          state   <= GAP;
          gap_cnt <= '0;
        end
`endif
        GAP: begin
          if (gap_cnt == GAP_W'(IDLE_BITS - 1)) begin
            state      <= IDLE;
            bus.done_o <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    serializer_8b #(.WIDTH(WIDTH)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .load   (xfer),
      .shift  (shift_en),
      .sel    (sel),
      .data   (bus.data_i[WIDTH*i +: WIDTH]),
      .serial (bus.serial_o[i])
    );
  end

endmodule

// File: tb/tb_full_mas_serializer.sv
// Directed bench for full_mas_serializer: vector table plus reset, back-to-back and loopback sequences.
// Expected frames adapt when FULL_MAS_SERIALIZER_PARITY_EN is defined.
module tb_full_mas_serializer;
  import full_mas_ser_pkg::*;

  localparam int unsigned L = 23;
  localparam int unsigned W = 8;
`ifdef FULL_MAS_SERIALIZER_PARITY_EN
  localparam int unsigned FRAME = 11;
`else
  localparam int unsigned FRAME = 10;
`endif
  localparam int unsigned PERIOD = FRAME + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  full_mas_serializer_if #(.LANES(L), .WIDTH(W)) bus ();

  full_mas_serializer #(.LANES(L), .WIDTH(W), .IDLE_BITS(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] b0, b11, b22;
    logic [9:0] s0, s11, s22;
    logic       p0, p11, p22;
  } vec_t;
  vec_t vecs[4];

  logic [L-1:0]     cap [FRAME];
  logic [FRAME-1:0] done_v, busy_v;

  function automatic logic [11:0] frame_of(input logic [9:0] s, input logic p);
`ifdef FULL_MAS_SERIALIZER_PARITY_EN
    return {1'b0, s[9:1], p, 1'b0};
`else
    return {2'b00, s};
`endif
  endfunction

  function automatic logic [11:0] lane_seq(input int unsigned lane);
    logic [11:0] s = '0;
    for (int unsigned k = 0; k < FRAME; k++) s[FRAME-1-k] = cap[k][lane];
    return s;
  endfunction

  function automatic logic [L*W-1:0] word_of(input vec_t v);
    logic [L*W-1:0] w = '0;
    w[7:0]       = v.b0;
    w[11*8 +: 8] = v.b11;
    w[22*8 +: 8] = v.b22;
    return w;
  endfunction

  // Present a word, wait (bounded) for acceptance, then record FRAME cycles after the accept edge.
  task automatic send_capture(input logic [L*W-1:0] w);
    int n = 0;
    @(negedge clk);
    bus.data_i  = w;
    bus.valid_i = 1'b1;
    while (!bus.ready_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("accept", 64'(bus.ready_o), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    for (int unsigned k = 0; k < FRAME; k++) begin
      @(posedge clk);
      #1;
      cap[k]            = bus.serial_o;
      done_v[FRAME-1-k] = bus.done_o;
      busy_v[FRAME-1-k] = bus.busy_o;
    end
  endtask

  initial begin
    logic [191:0]   rnd;
    logic [L*W-1:0] w, rec;
    int             bad, cnt;
    int             acc[$];
    int             low;

    vecs[0] = '{b0:8'hA5, b11:8'h00, b22:8'h3C, s0:10'b1101001010, s11:10'b1000000000,
                s22:10'b1001111000, p0:1'b0, p11:1'b0, p22:1'b0};
    vecs[1] = '{b0:8'hFF, b11:8'h01, b22:8'h80, s0:10'b1111111110, s11:10'b1100000000,
                s22:10'b1000000010, p0:1'b0, p11:1'b1, p22:1'b1};
    vecs[2] = '{b0:8'h5A, b11:8'h07, b22:8'h03, s0:10'b1010110100, s11:10'b1111000000,
                s22:10'b1110000000, p0:1'b0, p11:1'b1, p22:1'b0};
    vecs[3] = '{b0:8'h00, b11:8'hA5, b22:8'hFF, s0:10'b1000000000, s11:10'b1101001010,
                s22:10'b1111111110, p0:1'b0, p11:1'b0, p22:1'b0};

    // Reset held with valid high: nothing may be captured or driven.
    reset       = 1'b0;
    bus.valid_i = 1'b1;
    bus.data_i  = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_serial", 64'(bus.serial_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_done", 64'(bus.done_o), 64'd0);
    @(negedge clk);
    bus.valid_i = 1'b0;
    reset       = 1'b1;
    #1;
    chk("rst_ready", 64'(bus.ready_o), 64'd1);
    cnt = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus.serial_o != '0 || bus.busy_o) cnt++;
    end
    chk("idle_quiet", 64'(cnt), 64'd0);

    foreach (vecs[i]) begin
      send_capture(word_of(vecs[i]));
      chk("lane0_seq", 64'(lane_seq(0)), 64'(frame_of(vecs[i].s0, vecs[i].p0)));
      chk("lane11_seq", 64'(lane_seq(11)), 64'(frame_of(vecs[i].s11, vecs[i].p11)));
      chk("lane22_seq", 64'(lane_seq(22)), 64'(frame_of(vecs[i].s22, vecs[i].p22)));
      bad = 0;
      for (int unsigned l = 0; l < L; l++)
        if (l != 0 && l != 11 && l != 22 && lane_seq(l) !== frame_of(10'b1000000000, 1'b0)) bad++;
      chk("zero_lanes", 64'(bad), 64'd0);
      chk("done_pulse", 64'(done_v), 64'd1);
      chk("busy_window", 64'(busy_v), (64'd1 << FRAME) - 64'd2);
      chk("ready_after", 64'(bus.ready_o), 64'd1);
    end

    // Back-to-back: valid held high, accept spacing and ready duty.
    @(negedge clk);
    bus.data_i  = word_of(vecs[1]);
    bus.valid_i = 1'b1;
    low = 0;
    for (int c = 0; c < 100 && acc.size() < 4; c++) begin
      if (bus.ready_o) acc.push_back(c);
      else if (acc.size() > 0) low++;
      @(negedge clk);
    end
    bus.valid_i = 1'b0;
    chk("b2b_accepts", 64'(acc.size()), 64'd4);
    for (int i = 1; i < 4; i++)
      chk("b2b_period", 64'((acc.size() > i) ? acc[i] - acc[i-1] : 0), 64'(PERIOD));
    chk("b2b_ready_low", 64'(low), 64'(3 * (PERIOD - 1)));
    repeat (PERIOD + 2) @(posedge clk);

    // Loopback: rebuild each lane byte from the captured line.
    for (int n = 0; n < 6; n++) begin
      for (int j = 0; j < 6; j++) rnd[32*j +: 32] = $urandom;
      w = rnd[L*W-1:0];
      send_capture(w);
      for (int unsigned l = 0; l < L; l++)
        for (int unsigned b = 0; b < W; b++) rec[l*W + b] = cap[1 + b][l];
      chk("loop_start", 64'(cap[0]), 64'((64'd1 << L) - 64'd1));
      checks++;
      if (rec !== w) begin
        fails++;
        $display("FAIL loop_word: got %h expected %h", rec, w);
      end
    end

    // Reset during data bit 4 abandons the frame.
    @(negedge clk);
    bus.data_i  = word_of(vecs[0]);
    bus.valid_i = 1'b1;
    cnt = 0;
    while (!bus.ready_o && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    @(posedge clk);
    @(negedge clk);
    bus.valid_i = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("pre_rst_bit4", 64'(bus.serial_o[22]), 64'd1);
    chk("pre_rst_busy", 64'(bus.busy_o), 64'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_serial", 64'(bus.serial_o), 64'd0);
    chk("midrst_busy", 64'(bus.busy_o), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (bus.done_o || bus.serial_o != '0) cnt++;
    end
    chk("midrst_no_done", 64'(cnt), 64'd0);
    send_capture(word_of(vecs[0]));
    chk("post_rst_lane0", 64'(lane_seq(0)), 64'(frame_of(vecs[0].s0, vecs[0].p0)));
    chk("post_rst_lane22", 64'(lane_seq(22)), 64'(frame_of(vecs[0].s22, vecs[0].p22)));
    chk("post_rst_done", 64'(done_v), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
